// File: rtl/audio_buf_pkg.sv
// -----------------------------------------------------------------------------
// audio_buf_pkg
// Shared definitions for the audio sample buffer: default geometry, the
// address/length width and the control FSM state encoding.
// -----------------------------------------------------------------------------
package audio_buf_pkg;

    localparam int DEPTH_DEF = 2000;  // stereo frames stored
    localparam int DW_DEF    = 16;    // bits per channel sample
    localparam int ADDR_W    = 11;    // wide enough for 0..DEPTH_DEF

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_e;

endpackage : audio_buf_pkg

// File: rtl/audio_sample_buffer_if.sv
// -----------------------------------------------------------------------------
// audio_sample_buffer_if
// Codec-side and control signals of the audio sample buffer.
//   iLRCK               codec LR clock (asynchronous), rising edge = new frame
//   iAUD_inL/iAUD_inR   live samples from the converter
//   iREC                mode select sampled on start (1 = record, 0 = play)
//   iSTART              one-cycle start/stop pulse
//   oAUD_outL/oAUD_outR samples toward the converter
//   oBUSY               high while recording or playing
//   oDONE               one-cycle pulse when an operation ends
//   oLEN                frames currently held
// master: drives the inputs (stimulus / system side); slave: the buffer.
// -----------------------------------------------------------------------------
interface audio_sample_buffer_if #(
    parameter int DW = audio_buf_pkg::DW_DEF
);
    logic                              iLRCK;
    logic [DW-1:0]                     iAUD_inL;
    logic [DW-1:0]                     iAUD_inR;
    logic                              iREC;
    logic                              iSTART;
    logic [DW-1:0]                     oAUD_outL;
    logic [DW-1:0]                     oAUD_outR;
    logic                              oBUSY;
    logic                              oDONE;
    logic [audio_buf_pkg::ADDR_W-1:0]  oLEN;

    modport master (
        output iLRCK, iAUD_inL, iAUD_inR, iREC, iSTART,
        input  oAUD_outL, oAUD_outR, oBUSY, oDONE, oLEN
    );

    modport slave (
        input  iLRCK, iAUD_inL, iAUD_inR, iREC, iSTART,
        output oAUD_outL, oAUD_outR, oBUSY, oDONE, oLEN
    );

endinterface : audio_sample_buffer_if

// File: rtl/audio_buf_ram.sv
// -----------------------------------------------------------------------------
// audio_buf_ram
// Simple dual-port frame store, DEPTH x (2*DW). One write port, one read port,
// both synchronous; read data appears one cycle after iRE.
//   iCLK    clock
//   iWE     write enable, iWADDR / iWDATA write address / data
//   iRE     read enable,  iRADDR read address
//   oRDATA  registered read data
// -----------------------------------------------------------------------------
module audio_buf_ram
    import audio_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic              iCLK,
    input  logic              iWE,
    input  logic [ADDR_W-1:0] iWADDR,
    input  logic [2*DW-1:0]   iWDATA,
    input  logic              iRE,
    input  logic [ADDR_W-1:0] iRADDR,
    output logic [2*DW-1:0]   oRDATA
);

    logic [2*DW-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto block RAM; stale
    // contents are harmless because the controller only reads below oLEN.
    always_ff @(posedge iCLK) begin
        if (iWE) begin
            mem[iWADDR] <= iWDATA;
        end
        if (iRE) begin
            oRDATA <= mem[iRADDR];
        end
    end

endmodule : audio_buf_ram

// File: rtl/audio_sample_buffer.sv
// -----------------------------------------------------------------------------
// audio_sample_buffer
// Records stereo frames from the codec into a RAM on each LR-clock rising edge
// and plays them back on later frames. While idle or recording the outputs
// monitor the live inputs.
//   iCLK    single clock for all logic
//   iRST_N  asynchronous active-low reset
//   aud     codec / control signals (see audio_sample_buffer_if)
// -----------------------------------------------------------------------------
module audio_sample_buffer
    import audio_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    audio_sample_buffer_if.slave  aud
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // ---------------- LR clock synchronizer and frame tick ----------------
    logic       lrck_s1, lrck_s2, lrck_prev;
    logic [2:0] sync_valid;  // bit n set once stage n holds a real sample
    logic       tick;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            lrck_s1    <= 1'b0;
            lrck_s2    <= 1'b0;
            lrck_prev  <= 1'b0;
            sync_valid <= '0;
        end else begin
            lrck_s1    <= aud.iLRCK;
            lrck_s2    <= lrck_s1;
            lrck_prev  <= lrck_s2;
            sync_valid <= {sync_valid[1:0], 1'b1};
        end
    end

    // Edge detect only once lrck_prev holds a sampled value, so an LR clock
    // that is already high at reset release does not fake a frame.
    assign tick = lrck_s2 & ~lrck_prev & sync_valid[2];

    // ---------------- frame store ----------------
    logic              ram_we, ram_re;
    logic [2*DW-1:0]   ram_rdata;
    logic [ADDR_W-1:0] addr, addr_n;

    audio_buf_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
        .iCLK   (iCLK),
        .iWE    (ram_we),
        .iWADDR (addr),
        .iWDATA ({aud.iAUD_inL, aud.iAUD_inR}),
        .iRE    (ram_re),
        .iRADDR (addr),
        .oRDATA (ram_rdata)
    );

    // ---------------- control FSM ----------------
    state_e            state, state_n;
    logic [ADDR_W-1:0] len, len_n;
    logic [DW-1:0]     out_l, out_l_n, out_r, out_r_n;
    logic              done, done_n;
    logic              busy;
    logic              rd_pend, rd_pend_n;     // read data arrives this cycle
    logic              play_last, play_last_n; // pending read is the final frame

    // NOTE: every signal gets its default first so no path leaves a value
    // unassigned, which would infer a latch.
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        len_n       = len;
        out_l_n     = out_l;
        out_r_n     = out_r;
        done_n      = 1'b0;
        rd_pend_n   = 1'b0;
        play_last_n = play_last;
        ram_we      = 1'b0;
        ram_re      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // A start pulse consumes the cycle; a coincident tick is dropped.
                if (aud.iSTART) begin
                    if (aud.iREC) begin
                        state_n = ST_RECORD;
                        addr_n  = '0;
                        len_n   = '0;
                    end else if (len != '0) begin
                        state_n = ST_PLAY;
                        addr_n  = '0;
                    end else begin
                        done_n  = 1'b1;
                    end
                end else if (tick) begin
                    out_l_n = aud.iAUD_inL;
                    out_r_n = aud.iAUD_inR;
                end
            end

            ST_RECORD: begin
                if (aud.iSTART) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else if (tick) begin
                    ram_we  = 1'b1;
                    out_l_n = aud.iAUD_inL;
                    out_r_n = aud.iAUD_inR;
                    len_n   = addr + 1'b1;
                    if (addr == LAST_ADDR) begin
                        state_n = ST_IDLE;  // buffer full, addr stays put
                        done_n  = 1'b1;
                    end else begin
                        addr_n  = addr + 1'b1;
                    end
                end
            end

            ST_PLAY: begin
                if (rd_pend) begin
                    out_l_n = ram_rdata[2*DW-1:DW];
                    out_r_n = ram_rdata[DW-1:0];
                end
                if (aud.iSTART) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else if (rd_pend && play_last) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else if (tick) begin
                    ram_re      = 1'b1;
                    rd_pend_n   = 1'b1;
                    play_last_n = (addr == len - 1'b1);
                    if (addr != len - 1'b1) begin
                        addr_n = addr + 1'b1;
                    end
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= ST_IDLE;
            addr      <= '0;
            len       <= '0;
            out_l     <= '0;
            out_r     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            rd_pend   <= 1'b0;
            play_last <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            len       <= len_n;
            out_l     <= out_l_n;
            out_r     <= out_r_n;
            done      <= done_n;
            busy      <= (state_n != ST_IDLE);
            rd_pend   <= rd_pend_n;
            play_last <= play_last_n;
        end
    end

    assign aud.oAUD_outL = out_l;
    assign aud.oAUD_outR = out_r;
    assign aud.oBUSY     = busy;
    assign aud.oDONE     = done;
    assign aud.oLEN      = len;

endmodule : audio_sample_buffer

// File: tb/tb_audio_sample_buffer.sv
// -----------------------------------------------------------------------------
// tb_audio_sample_buffer
// Directed sequence with random sample data. The reference model is a queue of
// recorded frames plus the value the outputs should currently show.
// -----------------------------------------------------------------------------
module tb_audio_sample_buffer;

    localparam int DEPTH = 2000;
    localparam int DW    = 16;
    localparam int MODE_MON  = 0;  // outputs must show the live frame
    localparam int MODE_PLAY = 1;  // outputs must show a stored frame

    logic iCLK;
    logic iRST_N;

    audio_sample_buffer_if #(.DW(DW)) aud ();

    audio_sample_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .aud    (aud)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    logic [2*DW-1:0] model_q [$];  // frames the buffer should hold
    logic [2*DW-1:0] mout;         // value the outputs should be showing

    always @(negedge iCLK) begin
        if (aud.oDONE === 1'b1) done_cnt++;
        if (aud.oBUSY === 1'b1) busy_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic rec);
        @(negedge iCLK);
        aud.iREC   = rec;
        aud.iSTART = 1'b1;
        @(negedge iCLK);
        aud.iSTART = 1'b0;
    endtask

    // One LR-clock frame. The tick acts on the third rising clock edge after
    // the rise, so a monitored frame is visible 3 negedges after the rise and a
    // played frame (one extra RAM cycle) 4 negedges after it.
    task automatic lrck_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input int mode, input logic [2*DW-1:0] exp,
                              input logic [2*DW-1:0] prev);
        @(negedge iCLK);
        aud.iAUD_inL = l;
        aud.iAUD_inR = r;
        aud.iLRCK    = 1'b1;
        repeat (3) @(negedge iCLK);
        if (mode == MODE_PLAY)
            check("play_not_early", {aud.oAUD_outL, aud.oAUD_outR}, prev);
        @(negedge iCLK);
        check(mode == MODE_PLAY ? "play_data" : "monitor_data",
              {aud.oAUD_outL, aud.oAUD_outR}, exp);
        aud.iLRCK = 1'b0;
        repeat (3) @(negedge iCLK);
    endtask

    task automatic rec_frames(input int n, input logic counted);
        logic [DW-1:0] l, r;
        for (int i = 0; i < n; i++) begin
            l = DW'($urandom);
            r = DW'($urandom);
            lrck_frame(l, r, MODE_MON, {l, r}, mout);
            mout = {l, r};
            if (model_q.size() < DEPTH) model_q.push_back({l, r});
            if (counted) check("rec_len", 64'(aud.oLEN), 64'(model_q.size()));
        end
    endtask

    task automatic play_all();
        int d0;
        d0 = done_cnt;
        pulse_start(1'b0);
        check("play_busy", 64'(aud.oBUSY), 64'd1);
        for (int i = 0; i < model_q.size(); i++) begin
            lrck_frame(DW'($urandom), DW'($urandom), MODE_PLAY, model_q[i], mout);
            mout = model_q[i];
        end
        check("play_done", 64'(done_cnt - d0), 64'd1);
        check("play_idle", 64'(aud.oBUSY), 64'd0);
        check("play_hold", {aud.oAUD_outL, aud.oAUD_outR}, 64'(mout));
        check("play_len", 64'(aud.oLEN), 64'(model_q.size()));
    endtask

    int d0, b0;
    logic [DW-1:0] l, r;

    initial begin
        iRST_N       = 1'b0;
        aud.iLRCK    = 1'b0;
        aud.iAUD_inL = '0;
        aud.iAUD_inR = '0;
        aud.iREC     = 1'b0;
        aud.iSTART   = 1'b0;
        mout         = '0;
        repeat (3) @(negedge iCLK);
        check("rst_out", {aud.oAUD_outL, aud.oAUD_outR}, 64'd0);
        check("rst_busy", 64'(aud.oBUSY), 64'd0);
        check("rst_done", 64'(aud.oDONE), 64'd0);
        check("rst_len", 64'(aud.oLEN), 64'd0);
        iRST_N = 1'b1;
        repeat (4) @(negedge iCLK);

        // Idle monitor path.
        rec_frames(1, 1'b0);
        model_q.delete();

        // Playback request with nothing recorded.
        d0 = done_cnt; b0 = busy_cnt;
        pulse_start(1'b0);
        repeat (3) @(negedge iCLK);
        check("empty_play_done", 64'(done_cnt - d0), 64'd1);
        check("empty_play_busy", 64'(busy_cnt - b0), 64'd0);

        // Record five known frames, flip iREC mid-record, then abort.
        pulse_start(1'b1);
        check("rec_busy", 64'(aud.oBUSY), 64'd1);
        for (int n = 0; n < 5; n++) begin
            if (n == 2) aud.iREC = 1'b0;
            l = DW'(16'h1000 + n);
            r = DW'(16'h2000 + n);
            lrck_frame(l, r, MODE_MON, {l, r}, mout);
            mout = {l, r};
            model_q.push_back({l, r});
        end
        d0 = done_cnt;
        pulse_start(1'b1);
        repeat (2) @(negedge iCLK);
        check("abort_len", 64'(aud.oLEN), 64'd5);
        check("abort_done", 64'(done_cnt - d0), 64'd1);
        check("abort_busy", 64'(aud.oBUSY), 64'd0);

        play_all();

        // Start coincident with a tick at len=3: the frame is not recorded.
        model_q.delete();
        pulse_start(1'b1);
        rec_frames(3, 1'b1);
        d0 = done_cnt;
        @(negedge iCLK);
        aud.iAUD_inL = DW'($urandom);
        aud.iAUD_inR = DW'($urandom);
        aud.iLRCK    = 1'b1;
        repeat (2) @(negedge iCLK);
        aud.iSTART = 1'b1;
        @(negedge iCLK);
        aud.iSTART = 1'b0;
        @(negedge iCLK);
        aud.iLRCK = 1'b0;
        repeat (3) @(negedge iCLK);
        check("coinc_len", 64'(aud.oLEN), 64'd3);
        check("coinc_done", 64'(done_cnt - d0), 64'd1);
        check("coinc_busy", 64'(aud.oBUSY), 64'd0);
        play_all();

        // Reset in the middle of playback, with iLRCK high at release.
        pulse_start(1'b0);
        lrck_frame(DW'($urandom), DW'($urandom), MODE_PLAY, model_q[0], mout);
        @(negedge iCLK);
        #1 iRST_N = 1'b0;
        #1;
        check("midrst_out", {aud.oAUD_outL, aud.oAUD_outR}, 64'd0);
        check("midrst_len", 64'(aud.oLEN), 64'd0);
        check("midrst_busy", 64'(aud.oBUSY), 64'd0);
        check("midrst_done", 64'(aud.oDONE), 64'd0);
        aud.iLRCK    = 1'b1;
        aud.iAUD_inL = DW'($urandom) | DW'(1);
        aud.iAUD_inR = DW'($urandom) | DW'(1);
        @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (6) @(negedge iCLK);
        check("no_reset_tick", {aud.oAUD_outL, aud.oAUD_outR}, 64'd0);
        aud.iLRCK = 1'b0;
        repeat (3) @(negedge iCLK);
        model_q.delete();
        mout = '0;
        d0 = done_cnt; b0 = busy_cnt;
        pulse_start(1'b0);
        repeat (3) @(negedge iCLK);
        check("postrst_play_done", 64'(done_cnt - d0), 64'd1);
        check("postrst_play_busy", 64'(busy_cnt - b0), 64'd0);

        // Full-depth recording ends by itself; one more frame is not stored.
        d0 = done_cnt;
        pulse_start(1'b1);
        rec_frames(DEPTH, 1'b1);
        check("full_done", 64'(done_cnt - d0), 64'd1);
        check("full_busy", 64'(aud.oBUSY), 64'd0);
        check("full_len", 64'(aud.oLEN), 64'(DEPTH));
        rec_frames(1, 1'b1);
        play_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_audio_sample_buffer

// File: doc/audio_sample_buffer.md
AUDIO_SAMPLE_BUFFER -- requirements
Module: audio_sample_buffer

Interface
REQ-001 Parameter: DEPTH, 2000, number of stereo frames stored.
REQ-002 Parameter: DW, 16, sample width per channel.
REQ-003 Port: iCLK  input  1  single clock for all logic (audio control clock, 18.4 MHz nominal).
REQ-004 Port: iRST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: iLRCK  input  1  codec LR clock, asynchronous to iCLK; rising edge marks a new frame.
REQ-006 Port: iAUD_inL / iAUD_inR  input  DW each  live left/right samples from the converter, stable around iLRCK rising edge.
REQ-007 Port: iREC  input  1  mode select sampled at start: 1 = record, 0 = playback.
REQ-008 Port: iSTART  input  1  one-cycle start/stop pulse, already debounced.
REQ-009 Port: oAUD_outL / oAUD_outR  output  DW each  samples toward the converter.
REQ-010 Port: oBUSY  output  1  high in RECORD or PLAY.
REQ-011 Port: oDONE  output  1  one-cycle pulse when an operation ends.
REQ-012 Port: oLEN  output  11  frames currently held (0..DEPTH).

Function
REQ-013 iLRCK SHALL pass through a 2-flop synchronizer; frame tick = one-cycle pulse on synchronized rising edge (tick 3 iCLK cycles after the edge, +/-1).
REQ-014 FSM states SHALL be IDLE, RECORD, PLAY.
REQ-015 IDLE + iSTART with iREC=1 -> RECORD: addr=0, len=0; first write on the next tick.
REQ-016 IDLE + iSTART with iREC=0 and len>0 -> PLAY: addr=0; first read on the next tick.
REQ-017 IDLE + iSTART with iREC=0 and len=0 -> stay IDLE, pulse oDONE next cycle.
REQ-018 RECORD, each tick: write {iAUD_inL,iAUD_inR} to mem[addr]; addr++ and len++.
REQ-019 RECORD: the write of addr=DEPTH-1 SHALL end the operation: -> IDLE, len=DEPTH, oDONE pulse the following cycle.
REQ-020 PLAY, each tick: read mem[addr]; oAUD_outL/R update exactly 1 cycle after the tick (synchronous RAM read latency); addr++.
REQ-021 PLAY: after the frame at addr=len-1 is output -> IDLE, oDONE pulse; outputs hold the last frame.
REQ-022 iSTART in RECORD or PLAY SHALL abort -> IDLE with oDONE pulse; an abort during RECORD keeps len = frames written so far.
REQ-023 iSTART and tick in the same cycle in RECORD/PLAY: abort wins; that frame is not written or read.
REQ-024 iSTART and tick in the same cycle in IDLE: start wins; that tick is not used.
REQ-025 iREC changes outside a start cycle SHALL be ignored.
REQ-026 In IDLE and RECORD, oAUD_outL/R SHALL register the live inputs on each tick (monitor path).
REQ-027 addr is 11 bits and never exceeds DEPTH-1; there is no wrap-around, and the buffer stops when full.
REQ-028 oBUSY SHALL equal (state != IDLE), registered.

Reset
REQ-029 On iRST_N low: state=IDLE, addr=0, len=0, oAUD_outL/R=0, oBUSY=0, oDONE=0, synchronizer flops=0.
REQ-030 Reset mid-operation SHALL discard the recording (len=0); memory contents are not cleared and remain unreadable until a new recording.
REQ-031 The first tick after reset release SHALL NOT be generated from the synchronizer's reset value.

Structure
REQ-032 Shared package audio_buf_pkg SHALL hold: the state enum, DEPTH_DEF=2000, DW_DEF=16, ADDR_W=11.
REQ-033 Sub-module audio_buf_ram SHALL implement the storage: simple dual-port, DEPTH x 2*DW, synchronous write/read, 1-cycle read latency, no reset.

Verification
REQ-034 Record 5 frames (L=0x1000+n, R=0x2000+n), abort with iSTART -> oLEN=5, one oDONE pulse, oBUSY low.
REQ-035 Play back the 5 frames -> outputs 0x1000..0x1004 / 0x2000..0x2004, each 1 cycle after its tick; oDONE after the 5th frame.
REQ-036 Record with no abort -> ends after exactly 2000 ticks; oLEN=2000; the 2001st tick does not write.
REQ-037 Playback start with len=0 -> no PLAY entry; oDONE pulse; oBUSY stays 0.
REQ-038 iSTART coincident with a tick mid-RECORD at len=3 -> oLEN=3.
REQ-039 iRST_N asserted mid-PLAY -> all outputs 0 immediately, oLEN=0, state IDLE.
